fetch_unit: RTL and testbench

- RV32I instruction fetch front end. It produces the {instruction word, PC} stream that the instruction decoder consumes.
- Sequences the PC and issues word requests to instruction memory through a request/grant/response handshake.
- Buffers returned words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Applies redirects (taken branch, JAL, JALR) from the execute stage: flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch front end.
//
// Sequences the fetch PC, issues one word request at a time to instruction
// memory (req/gnt/rvalid handshake), buffers returned words in a small FIFO
// and presents {opcode, pc, fault} to the decoder with a valid/ready
// handshake. Redirects from execute flush the FIFO and drop stale responses.
//
// Parameters:
//   RESET_PC   - first fetch address after reset
//   FIFO_DEPTH - instruction buffer entries (power of two, >= 2)
//
// Ports:
//   i_clk, i_rst                - clock, synchronous active-high reset
//   o_imem_req, o_imem_addr     - fetch request and word address
//   i_imem_gnt                  - memory accepts the request this cycle
//   i_imem_rvalid/rdata/err     - response valid, instruction word, bus error
//   i_redirect, i_redirect_addr - one-cycle redirect pulse and new PC
//   o_valid, o_opcode, o_pc,
//   o_fault, i_ready            - decoder-side FIFO head and handshake
//
// Build option: define FETCH_MISALIGN_CHECK_EN to turn a misaligned redirect
// target into a single fault entry followed by a halt until the next
// redirect. Without it, redirect address bits [1:0] are cleared.

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_imem_err,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_addr,
   output logic        o_valid,
   output logic [31:0] o_opcode,
   output logic [31:0] o_pc,
   output logic        o_fault,
   input  logic        i_ready
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [1:0] ST_HALT = 2'd3;
`endif

   logic [1:0]    state, state_n;
   logic [31:0]   fetch_pc, req_pc;
   logic [31:0]   fifo_word  [FIFO_DEPTH];
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic          fifo_fault [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;

   logic          gnt_ok, pop, push, flush, stale;
   logic [31:0]   push_word, push_pc;
   logic          push_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic          misalign;
   logic          pend_fault;
   logic [31:0]   pend_pc;

   assign misalign = (i_redirect_addr[1:0] != 2'b00);
`else
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^i_redirect_addr[1:0];
`endif

   // Gate blocks new requests once every FIFO slot is owned by either a
   // buffered entry or the single outstanding request, so no overflow.
   assign o_imem_req  = ~i_rst & (state == ST_REQ) & (count < CW'(FIFO_DEPTH));
   assign o_imem_addr = fetch_pc;
   assign o_valid     = (count != '0);
   assign o_opcode    = fifo_word[rd_ptr];
   assign o_pc        = fifo_pc[rd_ptr];
   assign o_fault     = fifo_fault[rd_ptr];

   always_comb begin
      pop        = o_valid & i_ready;
      gnt_ok     = o_imem_req & i_imem_gnt;
      flush      = 1'b0;
      push       = 1'b0;
      push_word  = i_imem_err ? '0 : i_imem_rdata;
      push_pc    = req_pc;
      push_fault = i_imem_err;
      stale      = 1'b0;
      state_n    = state;
      if (i_redirect) begin
         flush = 1'b1;
         // A response landing in the redirect cycle retires the outstanding
         // request, so DROP is left immediately rather than waiting forever.
         stale = ((state == ST_REQ) && gnt_ok) ||
                 (((state == ST_WAIT) || (state == ST_DROP)) && !i_imem_rvalid);
         if (stale) begin
            state_n = ST_DROP;
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         else if (misalign) begin
            push       = 1'b1;
            push_word  = '0;
            push_pc    = i_redirect_addr;
            push_fault = 1'b1;
            state_n    = ST_HALT;
         end
`endif
         else begin
            state_n = ST_REQ;
         end
      end else begin
         case (state)
            ST_REQ: begin
               if (gnt_ok) state_n = ST_WAIT;
            end
            ST_WAIT: begin
               if (i_imem_rvalid) begin
                  push    = 1'b1;
                  state_n = ST_REQ;
               end
            end
            ST_DROP: begin
               if (i_imem_rvalid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                  if (pend_fault) begin
                     push       = 1'b1;
                     push_word  = '0;
                     push_pc    = pend_pc;
                     push_fault = 1'b1;
                     state_n    = ST_HALT;
                  end else begin
                     state_n = ST_REQ;
                  end
`else
                  state_n = ST_REQ;
`endif
               end
            end
            default: begin
               state_n = state;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_word[i]  <= '0;
            fifo_pc[i]    <= '0;
            fifo_fault[i] <= 1'b0;
         end
      end else begin
         state <= state_n;
         if (i_redirect) begin
            fetch_pc <= {i_redirect_addr[31:2], 2'b00};
         end else if (gnt_ok) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (flush) begin
            // Flush restarts the FIFO at slot 0; a same-cycle push (fault
            // entry) becomes the only entry.
            rd_ptr <= '0;
            if (push) begin
               fifo_word[0]  <= push_word;
               fifo_pc[0]    <= push_pc;
               fifo_fault[0] <= push_fault;
               wr_ptr        <= AW'(1);
               count         <= CW'(1);
            end else begin
               wr_ptr <= '0;
               count  <= '0;
            end
         end else begin
            if (push) begin
               fifo_word[wr_ptr]  <= push_word;
               fifo_pc[wr_ptr]    <= push_pc;
               fifo_fault[wr_ptr] <= push_fault;
               wr_ptr             <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_fault <= 1'b0;
         pend_pc    <= '0;
      end else if (i_redirect) begin
         pend_fault <= misalign;
         pend_pc    <= i_redirect_addr;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps followed by a randomized phase.
// A memory model answers granted requests after a chosen latency; the
// reference model is the expected program-order stream: after reset or a
// redirect, requests and delivered entries are consecutive words from the
// target, each carrying the memory word or a zero-word fault entry.

module tb_fetch_unit;

   logic        i_clk;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_imem_err;
   logic        i_redirect;
   logic [31:0] i_redirect_addr;
   logic        o_valid;
   logic [31:0] o_opcode;
   logic [31:0] o_pc;
   logic        o_fault;
   logic        i_ready;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_gnt      (i_imem_gnt),
      .i_imem_rvalid   (i_imem_rvalid),
      .i_imem_rdata    (i_imem_rdata),
      .i_imem_err      (i_imem_err),
      .i_redirect      (i_redirect),
      .i_redirect_addr (i_redirect_addr),
      .o_valid         (o_valid),
      .o_opcode        (o_opcode),
      .o_pc            (o_pc),
      .o_fault         (o_fault),
      .i_ready         (i_ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          pops = 0;

   logic [31:0] exp_req = '0;
   logic [31:0] exp_out = '0;
   bit          halted = 1'b0;
   bit          mis_pend = 1'b0;
   logic [31:0] mis_pc = '0;

   logic [31:0] q_addr[$];
   int          q_due[$];

   int          gnt_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   int          ready_pct = 0;
   bit          redir_req = 1'b0;
   logic [31:0] redir_tgt = '0;
   bit          hook_en = 1'b0;
   logic [31:0] hook_addr = '0;
   logic [31:0] hook_tgt = '0;

   bit          gnt_now = 1'b0;
   bit          pop_now = 1'b0;
   logic [31:0] gnt_addr = '0;
   logic [31:0] pop_pc = '0;
   bit          prev_req = 1'b0;
   bit          prev_gnt = 1'b0;
   bit          prev_redir = 1'b0;
   bit          prev_redir_chk = 1'b0;
   logic [31:0] prev_addr = '0;
   bit          dead_seen = 1'b0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0013;
         32'h4:   return 32'h0010_0093;
         32'h8:   return 32'hDEAD_BEEF;
         default: return (a * 32'h0019_660D) + 32'h3C6E_F35F;
      endcase
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return (a == 32'h20) || ((a >= 32'h1000) && (a[4:2] == 3'd5));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      vectors++;
      miscompares++;
      $error("FAIL %s: observed no DUT event within budget, expected one", tag);
   endtask

   task automatic apply_redirect(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (t[1:0] != 2'b00) begin
         mis_pend = 1'b1;
         mis_pc   = t;
         halted   = 1'b1;
         return;
      end
      halted   = 1'b0;
      mis_pend = 1'b0;
`endif
      exp_req        = {t[31:2], 2'b00};
      exp_out        = {t[31:2], 2'b00};
      prev_redir_chk = 1'b1;
   endtask

   // One clock cycle, entered just after a falling edge.
   task automatic cycle();
      logic        s_req, s_valid, s_fault, gnt, rv, er, rd, rdy;
      logic [31:0] s_addr, s_op, s_pc, rdat, raddr, rtgt;
      s_req   = o_imem_req;
      s_addr  = o_imem_addr;
      s_valid = o_valid;
      s_op    = o_opcode;
      s_pc    = o_pc;
      s_fault = o_fault;

      if (s_req) check("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
      if (prev_req && !prev_gnt && !prev_redir) begin
         check("req_hold", {31'd0, s_req}, 32'd1);
         check("addr_hold", s_addr, prev_addr);
      end
      if (prev_redir_chk) check("valid_after_redirect", {31'd0, s_valid}, 32'd0);
      if (halted) check("no_req_halted", {31'd0, s_req}, 32'd0);
      if (s_valid && s_op == 32'hDEAD_BEEF) dead_seen = 1'b1;

      rv = 1'b0; er = 1'b0; rdat = '0;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         raddr = q_addr.pop_front();
         void'(q_due.pop_front());
         rv   = 1'b1;
         er   = err_of(raddr);
         rdat = er ? $urandom : word_of(raddr);
      end
      gnt  = s_req && (int'($urandom_range(0, 99)) < gnt_pct);
      rd   = redir_req;
      rtgt = redir_tgt;
      redir_req = 1'b0;
      if (hook_en && s_req && s_addr == hook_addr) begin
         gnt     = 1'b1;
         rd      = 1'b1;
         rtgt    = hook_tgt;
         hook_en = 1'b0;
      end
      rdy = (int'($urandom_range(0, 99)) < ready_pct);

      i_imem_gnt      = gnt;
      i_imem_rvalid   = rv;
      i_imem_rdata    = rdat;
      i_imem_err      = er;
      i_redirect      = rd;
      i_redirect_addr = rtgt;
      i_ready         = rdy;
      #1;

      gnt_now = gnt;
      pop_now = s_valid && rdy;
      if (gnt) begin
         gnt_addr = s_addr;
         check("gnt_addr", s_addr, exp_req);
         exp_req = exp_req + 32'd4;
         q_addr.push_back(s_addr);
         q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      end
      if (pop_now) begin
         pop_pc = s_pc;
         pops++;
         if (mis_pend) begin
            check("fault_op", s_op, 32'd0);
            check("fault_pc", s_pc, mis_pc);
            check("fault_flag", {31'd0, s_fault}, 32'd1);
            mis_pend = 1'b0;
         end else if (halted) begin
            check("pop_while_halted", {31'd0, s_valid}, 32'd0);
         end else begin
            check("pop_pc", s_pc, exp_out);
            check("pop_op", s_op, err_of(exp_out) ? 32'd0 : word_of(exp_out));
            check("pop_fault", {31'd0, s_fault}, {31'd0, err_of(exp_out)});
            exp_out = exp_out + 32'd4;
         end
      end
      prev_redir_chk = 1'b0;
      if (rd) apply_redirect(rtgt);
      prev_req   = s_req;
      prev_addr  = s_addr;
      prev_gnt   = gnt;
      prev_redir = rd;
      cyc++;
      @(negedge i_clk);
      #1;
   endtask

   task automatic wait_gnt(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (gnt_now) return;
      end
      timeout(tag);
   endtask

   task automatic wait_pop(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (pop_now) return;
      end
      timeout(tag);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (o_valid) return;
         cycle();
      end
      timeout(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      i_rst = 1'b1;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_imem_err = 1'b0;
      i_redirect = 1'b0; i_redirect_addr = '0; i_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_req", {31'd0, o_imem_req}, 32'd0);
      check("rst_addr", o_imem_addr, 32'h0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_opcode", o_opcode, 32'd0);
      check("rst_pc", o_pc, 32'd0);
      check("rst_fault", {31'd0, o_fault}, 32'd0);
      i_rst = 1'b0;
      #1;

      // Immediate grant, 1-cycle responses, decoder stalled: fill the FIFO.
      repeat (6) cycle();
      check("full_req_low", {31'd0, o_imem_req}, 32'd0);
      check("head0_valid", {31'd0, o_valid}, 32'd1);
      check("head0_op", o_opcode, 32'h0000_0013);
      check("head0_pc", o_pc, 32'h0);

      ready_pct = 100;
      cycle();
      ready_pct = 0;
      check("pop0_pc", pop_pc, 32'h0);
      check("head1_op", o_opcode, 32'h0010_0093);
      check("head1_pc", o_pc, 32'h4);

      // Redirect while waiting on 0x8; its response lands 3 cycles later.
      lat_min = 4; lat_max = 4;
      wait_gnt("gnt_8", 4);
      check("gnt_8_addr", gnt_addr, 32'h8);
      lat_min = 1; lat_max = 1;
      redir_req = 1'b1; redir_tgt = 32'h100;
      cycle();
      wait_gnt("gnt_100", 10);
      check("gnt_100_addr", gnt_addr, 32'h100);
      ready_pct = 100;
      wait_pop("pop_100", 10);
      check("pop_100_pc", pop_pc, 32'h100);
      check("no_deadbeef", {31'd0, dead_seen}, 32'd0);

      // Redirect in the same cycle as the grant for 0x10.
      redir_req = 1'b1; redir_tgt = 32'h10;
      hook_en = 1'b1; hook_addr = 32'h10; hook_tgt = 32'h200;
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && hook_en; i++) cycle();
      if (hook_en) timeout("gnt_10");
      lat_min = 1; lat_max = 1;
      wait_gnt("gnt_200", 10);
      check("gnt_200_addr", gnt_addr, 32'h200);
      wait_pop("pop_200", 10);
      check("pop_200_pc", pop_pc, 32'h200);

      // Bus error on 0x20.
      ready_pct = 0;
      redir_req = 1'b1; redir_tgt = 32'h20;
      cycle();
      wait_valid("valid_20", 10);
      check("err_op", o_opcode, 32'h0);
      check("err_pc", o_pc, 32'h20);
      check("err_fault", {31'd0, o_fault}, 32'd1);
      wait_gnt("gnt_24", 10);
      check("gnt_24_addr", gnt_addr, 32'h24);
      ready_pct = 100;
      wait_pop("pop_20", 10);
      check("pop_20_pc", pop_pc, 32'h20);

      // Misaligned redirect target.
      ready_pct = 0;
      redir_req = 1'b1; redir_tgt = 32'h102;
      cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
      wait_valid("valid_102", 10);
      check("mis_pc", o_pc, 32'h102);
      check("mis_fault", {31'd0, o_fault}, 32'd1);
      check("mis_op", o_opcode, 32'h0);
      ready_pct = 100;
      cycle();
      repeat (10) cycle();
      check("halt_no_req", {31'd0, o_imem_req}, 32'd0);
      redir_req = 1'b1; redir_tgt = 32'h300;
      cycle();
      wait_gnt("gnt_300", 10);
      check("gnt_300_addr", gnt_addr, 32'h300);
`else
      wait_gnt("gnt_mis", 10);
      check("gnt_mis_addr", gnt_addr, 32'h100);
      ready_pct = 100;
      wait_pop("pop_mis", 10);
      check("pop_mis_pc", pop_pc, 32'h100);
`endif

      // Randomized traffic: grant gaps, variable latency, decoder stalls,
      // redirects including targets that wrap past 0xFFFF_FFFC.
      gnt_pct = 70; lat_min = 1; lat_max = 4; ready_pct = 60;
      p0 = pops;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            redir_req = 1'b1;
            if ($urandom_range(0, 3) == 0)
               redir_tgt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4);
            else
               redir_tgt = 32'h1000 + 32'($urandom_range(0, 1023) * 4);
         end
         cycle();
      end
      check("random_progress", {31'd0, (pops - p0) >= 200}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
